// File: rtl/d_ff64.sv
// WIDTH-bit D register built from per-bit hold/load mux cells, each with a synchronous
// active-high clear. Port order is fixed because register-file instances connect positionally.

module d_ff64_cell (
   output logic q,
   input  logic d,
   input  logic reset,
   input  logic clk,
   input  logic enable
);

   logic mux_s;
   logic q_r;

   // Hold/load select: recirculate the stored bit unless enable is high.
   always_comb begin
      mux_s = q_r;
      if (enable) begin
         mux_s = d;
      end else begin
         mux_s = q_r;
      end
   end

   // Storage flop; reset takes priority over the mux output.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r <= 1'b0;
      end else begin
         q_r <= mux_s;
      end
   end

   assign q = q_r;

endmodule

module d_ff64 #(
   parameter int WIDTH = 64
) (
   output logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             reset,
   input  logic             clk,
   input  logic             enable
);

   logic [WIDTH-1:0] cell_q_s;

   // Each bit is an independent cell; no bit ever sees a neighbour's data.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      d_ff64_cell u_cell (
         .q      (cell_q_s[i]),
         .d      (d[i]),
         .reset  (reset),
         .clk    (clk),
         .enable (enable)
      );
   end

   assign q = cell_q_s;

endmodule

// File: tb/tb_d_ff64.sv
// Scoreboard bench for d_ff64: expected q is pushed when stimulus is driven and
// popped for comparison one rising edge later.

module tb_d_ff64;

   logic        clk = 1'b0;
   logic [63:0] q;
   logic [63:0] d = 64'd0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;

   int          total = 0;
   int          bad = 0;
   logic [63:0] sb_q[$];
   logic [63:0] model_q;
   logic [63:0] exp_v;

   always #5 clk = ~clk;

   d_ff64 dut (
      .q      (q),
      .d      (d),
      .reset  (reset),
      .clk    (clk),
      .enable (enable)
   );

   // Drive one edge worth of stimulus, queue the expected result, settle after the edge.
   task automatic apply(input logic [63:0] dv, input logic rv, input logic ev);
      @(negedge clk);
      d = dv;
      reset = rv;
      enable = ev;
      if (rv) model_q = 64'd0;
      else if (ev) model_q = dv;
      sb_q.push_back(model_q);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      exp_v = sb_q.pop_front(); total++;
      if (q !== exp_v) begin bad++; $display("FAIL reset_edge1: q=%h exp=%h", q, exp_v); end
      apply(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      exp_v = sb_q.pop_front(); total++;
      if (q !== exp_v) begin bad++; $display("FAIL reset_edge2: q=%h exp=%h", q, exp_v); end
      apply(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
      exp_v = sb_q.pop_front(); total++;
      if (q !== exp_v || q !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         bad++; $display("FAIL reset_release_load: q=%h exp=%h", q, exp_v);
      end
   endtask

   task automatic test_load_hold();
      apply(64'd8675309, 1'b0, 1'b1);
      exp_v = sb_q.pop_front(); total++;
      if (q !== exp_v || q !== 64'd8675309) begin bad++; $display("FAIL load: q=%h exp=%h", q, exp_v); end
      for (int i = 0; i < 3; i++) begin
         apply(64'h1234, 1'b0, 1'b0);
         exp_v = sb_q.pop_front(); total++;
         if (q !== exp_v || q !== 64'd8675309) begin
            bad++; $display("FAIL hold%0d: q=%h exp=%h", i, q, exp_v);
         end
      end
   endtask

   task automatic test_reset_priority();
      apply(64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 1'b1);
      exp_v = sb_q.pop_front(); total++;
      if (q !== exp_v || q !== 64'd0) begin bad++; $display("FAIL reset_wins: q=%h exp=%h", q, exp_v); end
   endtask

   task automatic test_sync_reset();
      apply(64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b1);
      exp_v = sb_q.pop_front(); total++;
      if (q !== exp_v) begin bad++; $display("FAIL preload: q=%h exp=%h", q, exp_v); end
      // Pulse reset entirely between edges.
      #1 reset = 1'b1;
      #1 reset = 1'b0;
      total++;
      if (q !== 64'hDEAD_BEEF_0BAD_F00D) begin
         bad++; $display("FAIL midcycle_reset_glitch: q=%h exp=%h", q, 64'hDEAD_BEEF_0BAD_F00D);
      end
      apply(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
      exp_v = sb_q.pop_front(); total++;
      if (q !== exp_v || q !== 64'hDEAD_BEEF_0BAD_F00D) begin
         bad++; $display("FAIL reset_pulse_no_edge: q=%h exp=%h", q, exp_v);
      end
      apply(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
      exp_v = sb_q.pop_front(); total++;
      if (q !== exp_v) begin bad++; $display("FAIL reset_across_edge: q=%h exp=%h", q, exp_v); end
      apply(64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
      exp_v = sb_q.pop_front(); total++;
      if (q !== exp_v) begin bad++; $display("FAIL reload_after_reset: q=%h exp=%h", q, exp_v); end
   endtask

   task automatic test_zero_reg();
      for (int i = 0; i < 6; i++) begin
         apply(64'd0, 1'b1, i[0]);
         exp_v = sb_q.pop_front(); total++;
         if (q !== exp_v || q !== 64'd0) begin bad++; $display("FAIL zero_reg%0d: q=%h exp=%h", i, q, exp_v); end
      end
   endtask

   task automatic test_walking();
      logic [63:0] pat;
      for (int k = 0; k < 64; k++) begin
         pat = 64'd1 << k;
         apply(pat, 1'b0, 1'b1);
         exp_v = sb_q.pop_front(); total++;
         if (q !== exp_v || q !== pat) begin bad++; $display("FAIL walk1_%0d: q=%h exp=%h", k, q, exp_v); end
      end
      for (int k = 0; k < 64; k++) begin
         pat = ~(64'd1 << k);
         apply(pat, 1'b0, 1'b1);
         exp_v = sb_q.pop_front(); total++;
         if (q !== exp_v || q !== pat) begin bad++; $display("FAIL walk0_%0d: q=%h exp=%h", k, q, exp_v); end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] r;
      for (int i = 0; i < 20; i++) begin
         r = {$urandom(), $urandom()};
         apply(r, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0);
         exp_v = sb_q.pop_front(); total++;
         if (q !== exp_v) begin bad++; $display("FAIL b2b_%0d: q=%h exp=%h", i, q, exp_v); end
      end
      total++;
      if (sb_q.size() != 0) begin bad++; $display("FAIL sb_empty: size=%0d exp=0", sb_q.size()); end
   endtask

   initial begin
      test_reset();
      test_load_hold();
      test_reset_priority();
      test_sync_reset();
      test_zero_reg();
      test_walking();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
